lut_interp_ctrl: RTL and testbench

Sequencing controller for the coarse-table quadratic interpolator. It accepts one 8-bit argument per transaction over a valid/ready handshake and issues three serial reads (entries idx-1, idx, idx+1) to an external single-port synchronous 64x8 table memory. It then evaluates the 3-point quadratic interpolation and presents the 8-bit result over a second valid/ready handshake. It sits between the requesting datapath and the shared table ROM, so the table needs only one read port.

---
 rtl/lut_interp_ctrl_if.sv | 24 ++
 rtl/lut_interp_ctrl.sv | 158 +++++++++++++++
 tb/tb_lut_interp_ctrl.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/lut_interp_ctrl_if.sv
// Handshake and table-memory bundle for the quadratic interpolation controller.
// The controller attaches as slave; the requester/table side uses master.
interface lut_interp_ctrl_if;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_x;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_y;
   logic       mem_en;
   logic [5:0] mem_addr;
   logic [7:0] mem_rdata;
   logic       busy;

   modport slave (
      input  in_valid, in_x, out_ready, mem_rdata,
      output in_ready, out_valid, out_y, mem_en, mem_addr, busy
   );

   modport master (
      output in_valid, in_x, out_ready, mem_rdata,
      input  in_ready, out_valid, out_y, mem_en, mem_addr, busy
   );
endinterface

// File: rtl/lut_interp_ctrl.sv
// Sequences three serial reads (idx-1, idx, idx+1) from a single-port table
// and evaluates the 3-point quadratic interpolation of the fetched entries.
module lut_interp_ctrl #(
   parameter int MEM_LATENCY = 1
) (
   input logic             clk,
   input logic             rst_n,
   lut_interp_ctrl_if.slave bus
);

   typedef enum logic [2:0] {IDLE, RD0, RD1, RD2, WAIT, OUT} state_t;

   state_t                       state_q, state_d;
   logic [5:0]                   idx_q, idx_d;
   logic [1:0]                   f_q, f_d;
   logic                         in_ready_q, in_ready_d;
   logic                         out_valid_q, out_valid_d;
   logic [7:0]                   out_y_q, out_y_d;
   logic                         mem_en_q, mem_en_d;
   logic [5:0]                   mem_addr_q, mem_addr_d;
   logic                         busy_q, busy_d;
   logic [7:0]                   y1_q, y1_d;
   logic [7:0]                   y2_q, y2_d;
   logic [MEM_LATENCY-1:0]       pipe_vld_q, pipe_vld_d;
   logic [MEM_LATENCY-1:0][1:0]  pipe_tag_q, pipe_tag_d;

   logic                         capture;
   logic [1:0]                   cap_tag;
   logic [7:0]                   y3;
   logic [7:0]                   d1, d2, t1, t2, result;
   logic [9:0]                   p1;
   logic [3:0]                   f_sq;
   logic [11:0]                  p2;

   assign capture = pipe_vld_q[MEM_LATENCY-1];
   assign cap_tag = pipe_tag_q[MEM_LATENCY-1];
   assign y3      = bus.mem_rdata;

   // y3 is taken straight off the read bus so the result loads on its capture edge
   assign d1     = y3 - y1_q;
   assign p1     = 10'(f_q) * 10'(d1);
   assign t1     = {1'b0, p1[9:3]};
   assign d2     = y1_q - {y2_q[6:0], 1'b0} + y3;
   assign f_sq   = 4'(f_q) * 4'(f_q);
   assign p2     = 12'(f_sq) * 12'(d2);
   assign t2     = {1'b0, p2[11:5]};
   assign result = y2_q + t1 + t2;

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      f_d         = f_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      out_y_d     = out_y_q;
      mem_en_d    = mem_en_q;
      mem_addr_d  = mem_addr_q;
      busy_d      = busy_q;
      y1_d        = y1_q;
      y2_d        = y2_q;

      // Tag records which of the three reads the memory is sampling this edge
      pipe_vld_d    = pipe_vld_q;
      pipe_tag_d    = pipe_tag_q;
      pipe_vld_d[0] = mem_en_q;
      pipe_tag_d[0] = (state_q == RD0) ? 2'd0 : (state_q == RD1) ? 2'd1 : 2'd2;
      for (int j = 1; j < MEM_LATENCY; j++) begin
         pipe_vld_d[j] = pipe_vld_q[j-1];
         pipe_tag_d[j] = pipe_tag_q[j-1];
      end

      if (capture && cap_tag == 2'd0) y1_d = bus.mem_rdata;
      if (capture && cap_tag == 2'd1) y2_d = bus.mem_rdata;

      case (state_q)
         IDLE: begin
            in_ready_d = 1'b1;
            if (bus.in_valid && in_ready_q) begin
               idx_d      = bus.in_x[7:2];
               f_d        = bus.in_x[1:0];
               mem_en_d   = 1'b1;
               mem_addr_d = bus.in_x[7:2] - 6'd1;
               in_ready_d = 1'b0;
               busy_d     = 1'b1;
               state_d    = RD0;
            end
         end
         RD0: begin
            mem_addr_d = idx_q;
            state_d    = RD1;
         end
         RD1: begin
            mem_addr_d = idx_q + 6'd1;
            state_d    = RD2;
         end
         RD2: begin
            mem_en_d = 1'b0;
            state_d  = WAIT;
         end
         WAIT: begin
            if (capture && cap_tag == 2'd2) begin
               out_valid_d = 1'b1;
               out_y_d     = result;
               state_d     = OUT;
            end
         end
         OUT: begin
            if (bus.out_ready) begin
               out_valid_d = 1'b0;
               busy_d      = 1'b0;
               in_ready_d  = 1'b1;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         f_q         <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_y_q     <= '0;
         mem_en_q    <= 1'b0;
         mem_addr_q  <= '0;
         busy_q      <= 1'b0;
         y1_q        <= '0;
         y2_q        <= '0;
         pipe_vld_q  <= '0;
         pipe_tag_q  <= '0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         f_q         <= f_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         out_y_q     <= out_y_d;
         mem_en_q    <= mem_en_d;
         mem_addr_q  <= mem_addr_d;
         busy_q      <= busy_d;
         y1_q        <= y1_d;
         y2_q        <= y2_d;
         pipe_vld_q  <= pipe_vld_d;
         pipe_tag_q  <= pipe_tag_d;
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_y     = out_y_q;
   assign bus.mem_en    = mem_en_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.busy      = busy_q;

endmodule

// File: tb/tb_lut_interp_ctrl.sv
// Directed bench for lut_interp_ctrl: one instance per table latency, each
// backed by a behavioural synchronous table with matching read latency.
module tb_lut_interp_ctrl;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   lut_interp_ctrl_if ifA ();
   lut_interp_ctrl_if ifB ();

   lut_interp_ctrl #(.MEM_LATENCY(1)) dutA (.clk(clk), .rst_n(rst_n), .bus(ifA.slave));
   lut_interp_ctrl #(.MEM_LATENCY(2)) dutB (.clk(clk), .rst_n(rst_n), .bus(ifB.slave));

   logic [7:0] tbl [64];
   logic [7:0] rdA  = '0;
   logic [7:0] r1B  = '0;
   logic [7:0] r2B  = '0;

   always @(posedge clk) begin
      if (ifA.mem_en) rdA <= tbl[ifA.mem_addr];
      if (ifB.mem_en) r1B <= tbl[ifB.mem_addr];
      r2B <= r1B;
   end
   assign ifA.mem_rdata = rdA;
   assign ifB.mem_rdata = r2B;

   int checkCount = 0;
   int errorCount = 0;

   logic       sInReady, sOutValid, sMemEn, sBusy;
   logic [7:0] sOutY;
   logic [5:0] sMemAddr;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
      end
   endtask

   task automatic sampleBus(input bit useB);
      if (useB) begin
         sInReady = ifB.in_ready; sOutValid = ifB.out_valid; sOutY = ifB.out_y;
         sMemEn = ifB.mem_en; sMemAddr = ifB.mem_addr; sBusy = ifB.busy;
      end else begin
         sInReady = ifA.in_ready; sOutValid = ifA.out_valid; sOutY = ifA.out_y;
         sMemEn = ifA.mem_en; sMemAddr = ifA.mem_addr; sBusy = ifA.busy;
      end
   endtask

   task automatic applyStimulus(input bit useB, input logic valid, input logic [7:0] x, input logic rdy);
      if (useB) begin
         ifB.in_valid = valid; ifB.in_x = x; ifB.out_ready = rdy;
      end else begin
         ifA.in_valid = valid; ifA.in_x = x; ifA.out_ready = rdy;
      end
   endtask

   task automatic fillTable(input bit square);
      for (int i = 0; i < 64; i++) tbl[i] = square ? 8'(i * i) : 8'(4 * i);
   endtask

   // Full transaction: accept, check read sequence and latency, optionally stall the consumer
   task automatic runTxn(input bit useB, input logic [7:0] x, input logic [7:0] expY,
                         input int lat, input int hold, input string name);
      logic [5:0] idx;
      logic [5:0] ea;
      int k;
      idx = x[7:2];
      @(negedge clk);
      applyStimulus(useB, 1'b1, x, 1'b0);
      sampleBus(useB);
      checkOutput({name, "_in_ready_idle"}, 32'(sInReady), 32'd1);
      @(posedge clk); #1;
      applyStimulus(useB, 1'b0, 8'h00, 1'b0);
      sampleBus(useB);
      ea = idx - 6'd1;
      checkOutput({name, "_in_ready_busy"}, 32'(sInReady), 32'd0);
      checkOutput({name, "_busy"}, 32'(sBusy), 32'd1);
      checkOutput({name, "_mem_en0"}, 32'(sMemEn), 32'd1);
      checkOutput({name, "_addr0"}, 32'(sMemAddr), 32'(ea));
      k = 0;
      while (k < 20) begin
         @(posedge clk); #1;
         k++;
         sampleBus(useB);
         if (k <= 2) begin
            ea = idx + 6'(k) - 6'd1;
            checkOutput({name, "_mem_en_rd"}, 32'(sMemEn), 32'd1);
            checkOutput({name, "_addr_rd"}, 32'(sMemAddr), 32'(ea));
         end else if (k == 3) begin
            checkOutput({name, "_mem_en_off"}, 32'(sMemEn), 32'd0);
         end
         if (sOutValid) break;
      end
      checkOutput({name, "_latency"}, 32'(k), 32'(3 + lat));
      checkOutput({name, "_out_y"}, 32'(sOutY), 32'(expY));
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         sampleBus(useB);
         checkOutput({name, "_hold_valid"}, 32'(sOutValid), 32'd1);
         checkOutput({name, "_hold_y"}, 32'(sOutY), 32'(expY));
         checkOutput({name, "_hold_in_ready"}, 32'(sInReady), 32'd0);
         applyStimulus(useB, 1'(i % 2), 8'hFF, 1'b0);
      end
      @(negedge clk);
      applyStimulus(useB, 1'b0, 8'h00, 1'b1);
      @(posedge clk); #1;
      applyStimulus(useB, 1'b0, 8'h00, 1'b0);
      sampleBus(useB);
      checkOutput({name, "_valid_drop"}, 32'(sOutValid), 32'd0);
      checkOutput({name, "_idle_busy"}, 32'(sBusy), 32'd0);
      checkOutput({name, "_idle_in_ready"}, 32'(sInReady), 32'd1);
   endtask

   initial begin
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
      applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
      fillTable(1'b0);
      repeat (3) @(negedge clk);
      sampleBus(1'b0);
      checkOutput("rst_in_ready", 32'(sInReady), 32'd0);
      checkOutput("rst_out_valid", 32'(sOutValid), 32'd0);
      checkOutput("rst_out_y", 32'(sOutY), 32'd0);
      checkOutput("rst_mem_en", 32'(sMemEn), 32'd0);
      checkOutput("rst_mem_addr", 32'(sMemAddr), 32'd0);
      checkOutput("rst_busy", 32'(sBusy), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      sampleBus(1'b0);
      checkOutput("post_rst_in_ready", 32'(sInReady), 32'd1);

      runTxn(1'b0, 8'h29, 8'd41, 1, 0, "lin_x29");
      runTxn(1'b0, 8'h00, 8'd0, 1, 0, "wrap_x00");
      runTxn(1'b0, 8'h02, 8'd2, 1, 0, "wrap_x02");
      runTxn(1'b0, 8'h29, 8'd41, 1, 10, "stall_x29");

      fillTable(1'b1);
      runTxn(1'b0, 8'h17, 8'd32, 1, 0, "sq_x17");

      // Abort a transaction while the controller is issuing its second read
      fillTable(1'b0);
      @(negedge clk);
      applyStimulus(1'b0, 1'b1, 8'h29, 1'b0);
      @(posedge clk); #1;
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      sampleBus(1'b0);
      checkOutput("abort_mem_en", 32'(sMemEn), 32'd0);
      checkOutput("abort_mem_addr", 32'(sMemAddr), 32'd0);
      checkOutput("abort_busy", 32'(sBusy), 32'd0);
      checkOutput("abort_in_ready", 32'(sInReady), 32'd0);
      checkOutput("abort_out_valid", 32'(sOutValid), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (6) begin
         @(posedge clk); #1;
         sampleBus(1'b0);
         checkOutput("abort_no_result", 32'(sOutValid), 32'd0);
      end
      runTxn(1'b0, 8'h29, 8'd41, 1, 0, "after_rst_x29");

      runTxn(1'b1, 8'h29, 8'd41, 2, 0, "lat2_x29");

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
